// File: rtl/uart_rx_param_if.sv
// Receiver-to-consumer bundle for uart_rx_param: word, valid/ready handshake and status flags.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 frame_err;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output data_out, valid, busy, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    input  ready
  );

  modport slave (
    input  data_out, valid, busy, frame_err, overrun,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    output ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, valid/ready output with overrun/framing flags.
// Optional parity check compiled in with UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_param_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = PARITY_ODD[0];
`endif

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
      !(STOP_BITS == 1 || STOP_BITS == 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_param: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_RECOVER
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sync1_q, rx_s_q;
  logic                 full_wrap;
  logic                 complete;
  logic                 accept;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 pbad_q, pbad_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  assign full_wrap = (clk_cnt_q == FULL_END);
  assign accept    = valid_q && bus.ready;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;
    complete  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    pbad_d    = pbad_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_END) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (full_wrap) begin
          clk_cnt_d = '0;
          sh_d      = {rx_s_q, sh_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            // bit_cnt is reused to count stop samples.
            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_wrap) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
          pbad_d    = (rx_s_q != ((^sh_q) ^ PAR_SENSE));
          perr_d    = pbad_d;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (full_wrap) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end else if (bit_cnt_q == STOP_LAST) begin
            state_d  = S_IDLE;
`ifdef UART_RX_PARITY_EN
            complete = !pbad_q;
`else
            complete = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A completion in the same cycle as a handshake replaces the consumed word.
    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      if (!valid_q || bus.ready) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus random frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 3 + CPB / 2 + (DB + PB + SB) * CPB;

  typedef enum int {K_GOOD, K_FERR, K_PERR} kind_e;
  typedef struct {
    int unsigned   due;
    logic [DB-1:0] word;
    kind_e         kind;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic ready = 1'b0;

  uart_rx_param_if #(.DATA_BITS(DB)) bus ();
  assign bus.ready = ready;

  uart_rx_param #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned   n_total = 0;
  int unsigned   n_bad   = 0;
  int unsigned   cyc     = 0;
  ev_t           evq[$];
  ev_t           ev;
  logic [DB-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          m_perr  = 1'b0;
  logic          pre_v;
  int unsigned   ferr_cnt  = 0;
  int unsigned   perr_cnt  = 0;
  logic          busy_seen = 1'b0;
  logic          prev_v    = 1'b0;
  int unsigned   rise_cyc  = 0;
  logic          rand_on   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: frame outcomes are scheduled at the edge the latency rule predicts,
  // then applied together with the valid/ready rules at that edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      pre_v  = m_valid;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      if (pre_v && ready) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      while (evq.size() != 0 && evq[0].due <= cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          K_GOOD: begin
            if (!pre_v || ready) begin
              m_data  = ev.word;
              m_valid = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end
          K_FERR:  m_ferr = 1'b1;
          default: m_perr = 1'b1;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("valid", bus.valid, m_valid);
    chk("data_out", bus.data_out, m_data);
    chk("overrun", bus.overrun, m_ovr);
    chk("frame_err", bus.frame_err, m_ferr);
`ifdef UART_RX_PARITY_EN
    chk("parity_err", bus.parity_err, m_perr);
    if (bus.parity_err) perr_cnt++;
`endif
    if (bus.frame_err) ferr_cnt++;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.valid && !prev_v) rise_cyc = cyc;
    prev_v = bus.valid;
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; leaves rx at the last stop-bit level.
  task automatic send_frame(input logic [DB-1:0] w, input bit stop_ok, input bit par_ok);
    int unsigned n;
    logic        par;
    n = cyc;
    if (PB != 0 && !par_ok) evq.push_back('{due: n + LAT - SB * CPB, word: w, kind: K_PERR});
    if (!stop_ok)
      evq.push_back('{due: n + LAT - (SB - 1) * CPB, word: w, kind: K_FERR});
    else if (par_ok || PB == 0)
      evq.push_back('{due: n + LAT, word: w, kind: K_GOOD});
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < DB; i++) begin
      rx = w[i];
      wait_cycles(CPB);
    end
    par = (^w) ^ PODD[0];
    if (PB != 0) begin
      rx = par_ok ? par : ~par;
      wait_cycles(CPB);
    end
    for (int s = 0; s < SB; s++) begin
      rx = (s == 0) ? stop_ok : 1'b1;
      wait_cycles(CPB);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    evq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
    #1;
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_data", bus.data_out, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n0;
    int unsigned f0;
    do_reset();

    // 1: basic frame, latency, hold, handshake
    n0 = cyc;
    ferr_cnt = 0;
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("t1_latency", rise_cyc - n0, LAT);
    chk("t1_data", bus.data_out, 8'hA5);
    wait_cycles(10);
    chk("t1_hold_valid", bus.valid, 1'b1);
    consume();
    chk("t1_valid_clr", bus.valid, 1'b0);
    chk("t1_no_ferr", ferr_cnt, 0);

    // 2: false start
    busy_seen = 1'b0;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(30);
    chk("t2_busy_seen", busy_seen, 1'b1);
    chk("t2_busy_idle", bus.busy, 1'b0);
    chk("t2_no_valid", bus.valid, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("t2_data", bus.data_out, 8'h3C);
    consume();

    // 3: framing error with break, then recovery
    ferr_cnt = 0;
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_cycles(40);
    chk("t3_busy_in_break", bus.busy, 1'b1);
    rx = 1'b1;
    wait_cycles(5);
    chk("t3_busy_released", bus.busy, 1'b0);
    chk("t3_ferr_pulses", ferr_cnt, 1);
    chk("t3_no_valid", bus.valid, 1'b0);
    wait_cycles(CPB);
    send_frame(8'h55, 1'b1, 1'b1);
    chk("t3_data", bus.data_out, 8'h55);
    consume();

    // 4: back-to-back overrun
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    chk("t4_data_kept", bus.data_out, 8'h11);
    chk("t4_overrun", bus.overrun, 1'b1);
    consume();
    chk("t4_valid_clr", bus.valid, 1'b0);
    chk("t4_overrun_clr", bus.overrun, 1'b0);

    // 5: ready on the completion edge replaces the word
    send_frame(8'h33, 1'b1, 1'b1);
    n0 = cyc;
    fork
      send_frame(8'h44, 1'b1, 1'b1);
      begin
        while (cyc < n0 + LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    chk("t5_data", bus.data_out, 8'h44);
    chk("t5_valid", bus.valid, 1'b1);
    chk("t5_no_overrun", bus.overrun, 1'b0);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      wait_cycles(CPB);
    end
    do_reset();
    send_frame(8'h81, 1'b1, 1'b1);
    chk("t5_after_reset", bus.data_out, 8'h81);
    consume();

`ifdef UART_RX_PARITY_EN
    // 6: parity pass / fail
    n0 = cyc;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("t6_latency", rise_cyc - n0, LAT);
    chk("t6_data", bus.data_out, 8'h07);
    consume();
    perr_cnt = 0;
    send_frame(8'h07, 1'b1, 1'b0);
    wait_cycles(4);
    chk("t6_perr_pulses", perr_cnt, 1);
    chk("t6_no_valid", bus.valid, 1'b0);
`endif

    // random frames with random consumer
    f0 = 0;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(negedge clk);
          ready = ($urandom_range(0, 3) == 0);
        end
        ready = 1'b0;
      end
      begin
        for (int f = 0; f < 24; f++) begin
          logic [DB-1:0] w;
          bit            sok;
          w   = DB'($urandom);
          sok = ($urandom_range(0, 6) != 0);
          send_frame(w, sok, $urandom_range(0, 5) != 0);
          if (!sok) begin
            rx = 1'b1;
            wait_cycles(CPB + $urandom_range(0, 5));
            f0++;
          end else begin
            wait_cycles($urandom_range(0, 2) * CPB + $urandom_range(0, 3));
          end
        end
        rand_on = 1'b0;
      end
    join
    @(negedge clk);
    ready = 1'b1;
    wait_cycles(4);
    ready = 1'b0;
    wait_cycles(4);
    chk("final_valid", bus.valid, 1'b0);
    chk("final_overrun", bus.overrun, 1'b0);
    chk("final_busy", bus.busy, 1'b0);
    chk("final_queue_empty", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
